// File: rtl/sudoku_pkg.sv
// Shared constants, FSM state encoding and the base puzzle table for the puzzle loader.
package sudoku_pkg;

  localparam int unsigned CELLS       = 81;
  localparam int unsigned NUM_PUZZLES = 8;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned PID_W       = 3;
  localparam int unsigned RND_W       = 11;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned SETUP_LSB   = 0;
  localparam int unsigned A_LSB       = 3;
  localparam int unsigned B_LSB       = 7;
  localparam int unsigned ROM_W       = NUM_PUZZLES * CELLS * DIGIT_W;
  localparam int unsigned ROM_IDX_W   = $clog2(ROM_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_FETCH,
    S_APPLY,
    S_WRITE,
    S_DONE
  } state_e;

  // Valid solved grids (row/column/box Latin pattern shifted per puzzle) thinned by a givens mask.
  function automatic logic [ROM_W-1:0] gen_puzzles();
    logic [ROM_W-1:0]     rom;
    logic [ROM_IDX_W-1:0] idx;
    int                   r;
    int                   c;
    int                   digit;
    rom = '0;
    for (int p = 0; p < int'(NUM_PUZZLES); p++) begin
      for (int i = 0; i < int'(CELLS); i++) begin
        r     = i / 9;
        c     = i % 9;
        digit = ((3 * (r % 3) + r / 3 + 4 * c + 4 + p) % 9) + 1;
        idx   = ROM_IDX_W'((p * int'(CELLS) + i) * int'(DIGIT_W));
        if (((i * 7 + p * 3) % 5) < 2) rom[idx +: DIGIT_W] = DIGIT_W'(digit);
      end
    end
    return rom;
  endfunction

  localparam logic [ROM_W-1:0] PUZZLE_ROM = gen_puzzles();

endpackage

// File: rtl/sudoku_base_rom.sv
// Combinational base-puzzle lookup: (puzzle, cell) -> 0 for blank or a given digit 1..9.
module sudoku_base_rom
  import sudoku_pkg::*;
(
  input  logic [PID_W-1:0]   i_puzzle_id,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [DIGIT_W-1:0] o_cell_c
);

  logic [ROM_IDX_W-1:0] w_idx;

  always_comb begin
    w_idx = ROM_IDX_W'((ROM_IDX_W'(i_puzzle_id) * ROM_IDX_W'(CELLS) + ROM_IDX_W'(i_addr))
                       * ROM_IDX_W'(DIGIT_W));
    o_cell_c = (i_addr < ADDR_W'(CELLS)) ? PUZZLE_ROM[w_idx +: DIGIT_W] : '0;
  end

endmodule

// File: rtl/sudoku_puzzle_loader.sv
// Pulls random words, picks a base puzzle, relabels digits by swaps and streams the board out.
module sudoku_puzzle_loader
  import sudoku_pkg::*;
#(
  parameter int unsigned NUM_SWAPS = 8
) (
  input  logic               in_clka,
  input  logic               in_rst_n,
  input  logic               start,
  output logic               rng_req,
  input  logic               rnd_valid,
  input  logic [RND_W-1:0]   rnd_data,
  output logic               wr_en,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DIGIT_W-1:0] wr_data,
  output logic [PID_W-1:0]   puzzle_id,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   reject_cnt
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [DIGIT_W-1:0]   r_map [1:9];
  logic [DIGIT_W-1:0]   r_a;
  logic [DIGIT_W-1:0]   r_b;
  logic [CNT_W-1:0]     r_swap_cnt;
  logic [CNT_W-1:0]     r_reject;
  logic [PID_W-1:0]     r_pid;
  logic [ADDR_W-1:0]    r_addr;
  logic [DIGIT_W-1:0]   w_a;
  logic [DIGIT_W-1:0]   w_b;
  logic                 w_ab_ok;
  logic                 w_last_swap;
  logic                 w_last_addr;
  logic [DIGIT_W-1:0]   w_cell;
  logic [DIGIT_W-1:0]   w_wr_data;

  assign w_a         = rnd_data[A_LSB +: DIGIT_W];
  assign w_b         = rnd_data[B_LSB +: DIGIT_W];
  assign w_ab_ok     = (w_a >= DIGIT_W'(1)) && (w_a <= DIGIT_W'(9)) &&
                       (w_b >= DIGIT_W'(1)) && (w_b <= DIGIT_W'(9));
  assign w_last_swap = (r_swap_cnt == CNT_W'(NUM_SWAPS - 1));
  assign w_last_addr = (r_addr == ADDR_W'(CELLS - 1));

  sudoku_base_rom u_rom (
    .i_puzzle_id (r_pid),
    .i_addr      (r_addr),
    .o_cell_c    (w_cell)
  );

  // State register
  always_ff @(posedge in_clka or negedge in_rst_n) begin
    if (!in_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state and state-decoded handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    rng_req     = 1'b0;
    wr_en       = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_SEED;
      end
      S_SEED: begin
        rng_req = 1'b1;
        if (rnd_valid) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        rng_req = 1'b1;
        if (rnd_valid && w_ab_ok) w_state_nxt = S_APPLY;
      end
      S_APPLY: begin
        w_state_nxt = w_last_swap ? S_WRITE : S_FETCH;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (wr_ready && w_last_addr) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Load datapath: digit map, swap/reject counters, puzzle select and write address
  always_ff @(posedge in_clka or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int d = 1; d <= 9; d++) r_map[d] <= DIGIT_W'(d);
      r_a        <= '0;
      r_b        <= '0;
      r_swap_cnt <= '0;
      r_reject   <= '0;
      r_pid      <= '0;
      r_addr     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int d = 1; d <= 9; d++) r_map[d] <= DIGIT_W'(d);
            r_swap_cnt <= '0;
            r_reject   <= '0;
            r_addr     <= '0;
          end
        end
        S_SEED: begin
          if (rnd_valid) r_pid <= rnd_data[SETUP_LSB +: PID_W];
        end
        S_FETCH: begin
          if (rnd_valid) begin
            if (w_ab_ok) begin
              r_a <= w_a;
              r_b <= w_b;
            end else if (r_reject != '1) begin
              r_reject <= r_reject + CNT_W'(1);
            end
          end
        end
        S_APPLY: begin
          r_map[r_a] <= r_map[r_b];
          r_map[r_b] <= r_map[r_a];
          r_swap_cnt <= r_swap_cnt + CNT_W'(1);
        end
        S_WRITE: begin
          if (wr_ready) r_addr <= w_last_addr ? '0 : r_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Blanks pass through; givens are relabelled through the swapped map
  always_comb begin
    w_wr_data = '0;
    if (wr_en && (w_cell != '0)) w_wr_data = r_map[w_cell];
  end

  assign wr_addr    = r_addr;
  assign wr_data    = w_wr_data;
  assign puzzle_id  = r_pid;
  assign reject_cnt = r_reject;

endmodule

// File: tb/tb_sudoku_puzzle_loader.sv
// Scoreboard bench for the puzzle loader: a digit-permutation model predicts each 81-cell stream.
module tb_sudoku_puzzle_loader;
  import sudoku_pkg::*;

  localparam int NSW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rng_req;
  logic        rnd_valid;
  logic [10:0] rnd_data;
  logic        wr_en;
  logic        wr_ready;
  logic [6:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [2:0]  puzzle_id;
  logic        busy;
  logic        done;
  logic [7:0]  reject_cnt;

  always #5 clk = ~clk;

  sudoku_puzzle_loader #(.NUM_SWAPS(NSW)) dut (
    .in_clka    (clk),
    .in_rst_n   (rst_n),
    .start      (start),
    .rng_req    (rng_req),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .puzzle_id  (puzzle_id),
    .busy       (busy),
    .done       (done),
    .reject_cnt (reject_cnt)
  );

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int pid;  int rej;  } sum_t;

  wr_t         exp_wr[$];
  sum_t        exp_sum[$];
  logic [10:0] stim_q[$];
  int checks = 0;
  int passes = 0;
  int m_map[10];
  int m_acc;
  int m_rej;
  int m_pid;
  bit m_seeded;
  bit gaps = 1'b0;
  int rdy_mode = 0;
  int wr_cycles_tot = 0;
  int done_tot = 0;
  int first_addr = -1;
  int board_seen[81];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic finish_sim();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: got no response within budget, expected one", name);
    finish_sim();
  endtask

  function automatic int rom_cell(input int p, input int i);
    logic [ROM_IDX_W-1:0] idx;
    idx = ROM_IDX_W'((p * 81 + i) * 4);
    return int'(PUZZLE_ROM[idx +: 4]);
  endfunction

  function automatic logic [10:0] rand_word();
    if ($urandom % 2 == 0) return 11'($urandom);
    return {4'($urandom_range(1, 9)), 4'($urandom_range(1, 9)), 3'($urandom)};
  endfunction

  task automatic model_reset();
    for (int d = 1; d <= 9; d++) m_map[d] = d;
    m_acc = 0;
    m_rej = 0;
    m_seeded = 1'b0;
  endtask

  // First consumed word selects the puzzle; later words are swaps or rejects
  task automatic model_word(input logic [10:0] d, output bit swapped);
    int a, b, t;
    swapped = 1'b0;
    if (!m_seeded) begin
      m_pid = int'(d[2:0]);
      m_seeded = 1'b1;
    end else begin
      a = int'(d[6:3]);
      b = int'(d[10:7]);
      if (a >= 1 && a <= 9 && b >= 1 && b <= 9) begin
        t = m_map[a]; m_map[a] = m_map[b]; m_map[b] = t;
        m_acc++;
        swapped = 1'b1;
      end else if (m_rej < 255) begin
        m_rej++;
      end
    end
  endtask

  task automatic push_expected();
    int v;
    for (int i = 0; i < 81; i++) begin
      v = rom_cell(m_pid, i);
      exp_wr.push_back('{i, (v == 0) ? 0 : m_map[v]});
    end
    exp_sum.push_back('{m_pid, m_rej});
  endtask

  // Present one word until the DUT consumes it
  task automatic offer(input logic [10:0] d);
    int  n;
    bit  first;
    bit  got;
    n = 0; first = 1'b1; got = 1'b0;
    while (!got) begin
      @(negedge clk);
      if (gaps && ($urandom % 4 == 0)) begin
        rnd_valid = 1'b0;
        rnd_data  = 11'($urandom);
      end else begin
        rnd_valid = 1'b1;
        rnd_data  = d;
        #1;
        if (first) begin
          chk("rng_req_high_in_fetch", int'(rng_req), 1);
          first = 1'b0;
        end
        if (rng_req) begin
          @(posedge clk);
          got = 1'b1;
        end
      end
      n++;
      if (n > 60) timeout("word_consume");
    end
  endtask

  task automatic run_load(input bit start_fetch, input bit start_write, input int abort_addr);
    logic [10:0] d;
    bit sw;
    bit pulsed;
    bit aborted;
    int n;
    int done0;
    done0 = done_tot;
    aborted = 1'b0;
    model_reset();
    @(negedge clk); start = 1'b1; rnd_valid = 1'b0;
    @(negedge clk); start = 1'b0; #1;
    chk("busy_after_start", int'(busy), 1);
    pulsed = 1'b0;
    while (m_acc < NSW) begin
      if (stim_q.size() > 0) d = stim_q.pop_front();
      else d = m_seeded ? rand_word() : 11'($urandom);
      offer(d);
      model_word(d, sw);
      if (start_fetch && !pulsed) begin
        @(negedge clk); rnd_valid = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk("stray_start_busy", int'(busy), 1);
        chk("stray_start_still_fetch", int'(rng_req), 1);
        pulsed = 1'b1;
      end
      if (sw) begin
        @(negedge clk); rnd_valid = 1'b1; rnd_data = 11'h128; #1;
        chk("rng_req_low_in_apply", int'(rng_req), 0);
      end
    end
    push_expected();
    n = 0;
    pulsed = 1'b0;
    while (busy) begin
      @(negedge clk);
      rnd_valid = 1'b0;
      start = 1'b0;
      if (start_write && !pulsed && wr_en && wr_addr == 7'd20) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      #3;
      if (abort_addr >= 0 && wr_en && int'(wr_addr) == abort_addr) begin
        rst_n = 1'b0; #1;
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rng_req", int'(rng_req), 0);
        @(negedge clk); @(negedge clk); #3;
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      n++;
      if (n > 700) timeout("load_complete");
    end
    start = 1'b0;
    if (!aborted) chk("done_pulses", done_tot - done0, 1);
  endtask

  // wr_ready driver: always ready, random back-pressure, or a 3-cycle stall at cell 40
  int stall_n = 0;
  always begin
    @(negedge clk);
    case (rdy_mode)
      0: wr_ready = 1'b1;
      1: wr_ready = ($urandom % 4) != 0;
      default: begin
        if (!wr_en) stall_n = 0;
        if (wr_en && wr_addr == 7'd40 && stall_n < 3) begin
          wr_ready = 1'b0;
          stall_n++;
        end else begin
          wr_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: pops expected writes and load summaries, checks hold-stability under back-pressure
  bit         stall_valid = 1'b0;
  bit         prev_wen = 1'b0;
  logic [6:0] stall_addr;
  logic [3:0] stall_data;
  wr_t        e;
  sum_t       s;
  always begin
    @(negedge clk); #2;
    if (!rst_n) begin
      exp_wr.delete();
      exp_sum.delete();
      stall_valid = 1'b0;
      prev_wen = 1'b0;
    end else begin
      if (wr_en) wr_cycles_tot++;
      if (wr_en && !prev_wen) first_addr = int'(wr_addr);
      prev_wen = wr_en;
      if (wr_en && stall_valid) begin
        chk("stall_addr_hold", int'(wr_addr), int'(stall_addr));
        chk("stall_data_hold", int'(wr_data), int'(stall_data));
      end
      stall_valid = wr_en && !wr_ready;
      stall_addr  = wr_addr;
      stall_data  = wr_data;
      if (wr_en && wr_ready) begin
        if (exp_wr.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr %0d, expected no write", wr_addr);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", int'(wr_addr), e.addr);
          chk($sformatf("wr_data_cell%0d", e.addr), int'(wr_data), e.data);
          if (int'(wr_addr) < 81) board_seen[wr_addr] = int'(wr_data);
        end
      end
      if (done) begin
        done_tot++;
        if (exp_sum.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done, expected none");
        end else begin
          s = exp_sum.pop_front();
          chk("puzzle_id", int'(puzzle_id), s.pid);
          chk("reject_cnt", int'(reject_cnt), s.rej);
          chk("writes_left_at_done", exp_wr.size(), 0);
        end
      end
    end
  end

  int w0;
  initial begin
    rst_n = 1'b0; start = 1'b0; rnd_valid = 1'b0; rnd_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rng_req", int'(rng_req), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_puzzle_id", int'(puzzle_id), 0);
    chk("rst_reject_cnt", int'(reject_cnt), 0);
    rst_n = 1'b1;

    // Puzzle 0, eight identical swaps cancel out, no back-pressure
    stim_q.push_back(11'h000);
    repeat (8) stim_q.push_back(11'h128);
    w0 = wr_cycles_tot;
    run_load(1'b0, 1'b0, -1);
    chk("write_cycles_unstalled", wr_cycles_tot - w0, 81);
    chk("cell0_value", board_seen[0], 5);
    chk("cell1_blank", board_seen[1], 0);
    chk("cell80_value", board_seen[80], 9);

    // rnd_valid while idle is not consumed
    repeat (4) begin @(negedge clk); rnd_valid = 1'b1; rnd_data = 11'h7FF; end
    @(negedge clk); rnd_valid = 1'b0; #1;
    chk("idle_pid_hold", int'(puzzle_id), m_pid);
    chk("idle_not_busy", int'(busy), 0);

    // Rejections (A=0, A=12, B=10), stray starts in FETCH and WRITE
    stim_q.push_back(11'h000);
    stim_q.push_back(11'h100);
    stim_q.push_back(11'h160);
    stim_q.push_back(11'h528);
    repeat (8) stim_q.push_back(rand_word() | 11'h088);
    run_load(1'b1, 1'b1, -1);

    // Three-cycle write stall at cell 40
    rdy_mode = 2;
    w0 = wr_cycles_tot;
    run_load(1'b0, 1'b0, -1);
    chk("write_cycles_stalled", wr_cycles_tot - w0, 84);
    rdy_mode = 0;

    // Reset mid-write, then restart on puzzle 3
    run_load(1'b0, 1'b0, 30);
    stim_q.push_back(11'h003);
    run_load(1'b0, 1'b0, -1);
    chk("restart_puzzle_id", int'(puzzle_id), 3);
    chk("restart_first_addr", first_addr, 0);

    // Reject counter saturation
    stim_q.push_back(11'h005);
    repeat (260) stim_q.push_back(11'h000);
    repeat (8) stim_q.push_back(11'h128);
    run_load(1'b0, 1'b0, -1);
    chk("reject_saturated", int'(reject_cnt), 255);

    // Fully random loads with gaps and back-pressure
    rdy_mode = 1;
    gaps = 1'b1;
    repeat (6) run_load(1'b0, 1'b0, -1);

    repeat (3) @(negedge clk);
    chk("expected_queue_drained", exp_wr.size() + exp_sum.size(), 0);
    finish_sim();
  end

endmodule
